// File: rtl/hs_pkg.sv
// Width helpers shared by the hs_fifo block: log2-ceiling plus the
// occupancy-count and ring-pointer width derivations.
package hs_pkg;

   function automatic int unsigned clog2_f(input int unsigned value);
      int unsigned result;
      int unsigned span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span << 1;
         result = result + 1;
      end
      return result;
   endfunction

   // Count must represent 0..depth inclusive.
   function automatic int unsigned occ_width_f(input int unsigned depth);
      return clog2_f(depth + 1);
   endfunction

   function automatic int unsigned ptr_width_f(input int unsigned depth);
      return (clog2_f(depth) < 1) ? 1 : clog2_f(depth);
   endfunction

endpackage

// File: rtl/hs_fifo_register.sv
// Generic enabled register with synchronous active-high clear; every
// state element of hs_fifo except the ring memory is one of these.
module hs_fifo_register #(
   parameter int unsigned     WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             clock_enable,
   input  logic [WIDTH-1:0] data_d,
   output logic [WIDTH-1:0] data_q
);

   always_ff @(posedge clock) begin
      if (clear) begin
         data_q <= RESET_VALUE;
      end else if (clock_enable) begin
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/hs_fifo.sv
// Valid/ready FIFO: DEPTH-1 word ring plus a registered output stage.
// Define HS_FIFO_OCCUPANCY_EN to expose the held-word count on occupancy.
module hs_fifo
   import hs_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 10,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  input_valid,
   output logic                  input_ready,
   input  logic [WORD_WIDTH-1:0] input_data,
   output logic                  output_valid,
   input  logic                  output_ready,
   output logic [WORD_WIDTH-1:0] output_data
`ifdef HS_FIFO_OCCUPANCY_EN
   ,
   output logic [occ_width_f(DEPTH)-1:0] occupancy
`endif
);

   localparam int unsigned    CW         = occ_width_f(DEPTH);
   localparam int unsigned    PW         = ptr_width_f(DEPTH);
   localparam int unsigned    RING_DEPTH = DEPTH - 1;
   localparam logic [PW-1:0]  PTR_LAST   = PW'(RING_DEPTH - 1);
   localparam logic [CW-1:0]  COUNT_FULL = CW'(DEPTH);

   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
   logic [WORD_WIDTH-1:0] ring_q [RING_DEPTH];

   logic insert;
   logic remove;
   logic ring_empty;
   logic out_free;
   logic ring_we;
   logic ring_pop;
   logic out_data_en;

   // Handshakes, ring/output-stage routing and next-state values.
   always_comb begin
      insert      = input_valid & in_ready_q;
      remove      = out_valid_q & output_ready;
      ring_empty  = (count_q == CW'(out_valid_q));
      out_free    = ~out_valid_q | remove;
      ring_we     = 1'b0;
      ring_pop    = 1'b0;
      out_data_en = 1'b0;
      out_data_d  = out_data_q;

      if (out_free && !ring_empty) begin
         // Refill the output stage from the ring; a concurrent insert queues behind.
         ring_pop    = 1'b1;
         out_data_en = 1'b1;
         out_data_d  = ring_q[rd_ptr_q];
         ring_we     = insert;
      end else if (out_free && insert) begin
         out_data_en = 1'b1;
         out_data_d  = input_data;
      end else begin
         ring_we = insert;
      end

      count_d     = count_q + CW'(insert) - CW'(remove);
      wr_ptr_d    = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      in_ready_d  = (count_d < COUNT_FULL);
      out_valid_d = (count_d != '0);
   end

   // Ring storage holds no reset; the pointers define what is live.
   always_ff @(posedge clock) begin
      if (ring_we && !clear) begin
         ring_q[wr_ptr_q] <= input_data;
      end
   end

   hs_fifo_register #(.WIDTH(CW), .RESET_VALUE('0)) u_count (
      .clock        (clock),
      .clear        (clear),
      .clock_enable (insert | remove),
      .data_d       (count_d),
      .data_q       (count_q)
   );

   hs_fifo_register #(.WIDTH(PW), .RESET_VALUE('0)) u_wr_ptr (
      .clock        (clock),
      .clear        (clear),
      .clock_enable (ring_we),
      .data_d       (wr_ptr_d),
      .data_q       (wr_ptr_q)
   );

   hs_fifo_register #(.WIDTH(PW), .RESET_VALUE('0)) u_rd_ptr (
      .clock        (clock),
      .clear        (clear),
      .clock_enable (ring_pop),
      .data_d       (rd_ptr_d),
      .data_q       (rd_ptr_q)
   );

   hs_fifo_register #(.WIDTH(1), .RESET_VALUE(1'b1)) u_in_ready (
      .clock        (clock),
      .clear        (clear),
      .clock_enable (1'b1),
      .data_d       (in_ready_d),
      .data_q       (in_ready_q)
   );

   hs_fifo_register #(.WIDTH(1), .RESET_VALUE(1'b0)) u_out_valid (
      .clock        (clock),
      .clear        (clear),
      .clock_enable (1'b1),
      .data_d       (out_valid_d),
      .data_q       (out_valid_q)
   );

   hs_fifo_register #(.WIDTH(WORD_WIDTH), .RESET_VALUE('0)) u_out_data (
      .clock        (clock),
      .clear        (clear),
      .clock_enable (out_data_en),
      .data_d       (out_data_d),
      .data_q       (out_data_q)
   );

   assign input_ready  = in_ready_q;
   assign output_valid = out_valid_q;
   assign output_data  = out_data_q;

`ifdef HS_FIFO_OCCUPANCY_EN
   assign occupancy = count_q;
`endif

endmodule

// File: tb/tb_hs_fifo.sv
// Scoreboard bench for hs_fifo (WORD_WIDTH=10, DEPTH=4): directed scenarios
// plus a seeded random-ready run, checked against a queue-based model.
module tb_hs_fifo;

   localparam int WW = 10;
   localparam int DP = 4;

   logic          clock = 1'b0;
   logic          clear = 1'b1;
   logic          input_valid = 1'b0;
   logic          input_ready;
   logic [WW-1:0] input_data = '0;
   logic          output_valid;
   logic          output_ready = 1'b0;
   logic [WW-1:0] output_data;
`ifdef HS_FIFO_OCCUPANCY_EN
   logic [2:0]    occupancy;
`endif

   int            tests = 0;
   int            fails = 0;
   logic [WW-1:0] exp_q[$];
   bit            started = 1'b0;
   int            model_cnt = 0;
   logic          prev_clear = 1'b0;
   logic          prev_hold = 1'b0;
   logic [WW-1:0] prev_data = '0;
   logic          mon_ins;
   logic          mon_rem;

   always #5 clock = ~clock;

   hs_fifo #(.WORD_WIDTH(WW), .DEPTH(DP)) dut (
      .clock        (clock),
      .clear        (clear),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_data  (output_data)
`ifdef HS_FIFO_OCCUPANCY_EN
      ,
      .occupancy    (occupancy)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; accepted words go to the scoreboard.
   task automatic step(input logic v, input logic [WW-1:0] d, input logic rdy,
                       input logic clr, output logic ins);
      @(posedge clock);
      #1;
      clear        = clr;
      input_valid  = v;
      input_data   = d;
      output_ready = rdy;
      ins = v && input_ready && !clr;
      if (ins) exp_q.push_back(d);
   endtask

   // Monitor: status from the model count, data from the scoreboard head.
   always @(negedge clock) begin
      if (started) begin
         check("input_ready", 32'(input_ready), 32'(model_cnt < DP));
         check("output_valid", 32'(output_valid), 32'(model_cnt != 0));
`ifdef HS_FIFO_OCCUPANCY_EN
         check("occupancy", 32'(occupancy), 32'(model_cnt));
`endif
         if (prev_clear) check("clear_output_data", 32'(output_data), 32'h0);
         if (prev_hold) check("hold_stable", 32'(output_data), 32'(prev_data));
         if (output_valid) begin
            if (exp_q.size() != 0) begin
               check("head_data", 32'(output_data), 32'(exp_q[0]));
               if (output_ready && !clear) void'(exp_q.pop_front());
            end else begin
               check("head_present", 32'(exp_q.size() != 0), 32'd1);
            end
         end
      end
      mon_ins = input_valid && input_ready && !clear;
      mon_rem = output_valid && output_ready && !clear;
      if (clear) begin
         model_cnt = 0;
         exp_q.delete();
         started = 1'b1;
      end else begin
         model_cnt = model_cnt + int'(mon_ins) - int'(mon_rem);
      end
      prev_clear = clear;
      prev_hold  = output_valid && !output_ready && !clear;
      prev_data  = output_data;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic ins;
      int   sent;
      int   budget;

      // Reset with a word offered: it must not be taken.
      step(1'b1, 10'h3FF, 1'b0, 1'b1, ins);
      step(1'b1, 10'h3FF, 1'b0, 1'b1, ins);

      // Fill with output stalled.
      for (int i = 1; i <= 4; i++) step(1'b1, WW'(i), 1'b0, 1'b0, ins);
      step(1'b0, '0, 1'b0, 1'b0, ins);
      step(1'b0, '0, 1'b0, 1'b0, ins);

      // Drain.
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, ins);

      // Back-to-back streaming.
      for (int i = 0; i < 16; i++) step(1'b1, WW'(16 + i), 1'b1, 1'b0, ins);
      step(1'b0, '0, 1'b1, 1'b0, ins);
      step(1'b0, '0, 1'b1, 1'b0, ins);

      // Random output_ready across pointer wraps.
      void'($urandom(1));
      sent   = 0;
      budget = 0;
      while (sent < 20 && budget < 400) begin
         step(1'b1, WW'($urandom), 1'($urandom), 1'b0, ins);
         if (ins) sent++;
         budget++;
      end
      check("wrap_words_accepted", 32'(sent), 32'd20);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, ins);

      // Clear while full, then a fresh word must come out first.
      for (int i = 1; i <= 4; i++) step(1'b1, WW'(i), 1'b0, 1'b0, ins);
      step(1'b0, '0, 1'b0, 1'b0, ins);
      step(1'b1, 10'h2AA, 1'b1, 1'b1, ins);
      step(1'b1, 10'h055, 1'b0, 1'b0, ins);
      step(1'b0, '0, 1'b0, 1'b0, ins);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, ins);

      @(negedge clock);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
